interpolate_4: RTL and testbench

Fixed-ratio 1:4 interpolator for the baseband sample path. It accepts one W-bit signed sample every four clocks through a valid/ready handshake and emits one output sample every clock. Output is produced by zero-stuffing, sample-hold or linear interpolation. It is the upsampling counterpart of the team's divide-by-4 decimator and sits on the transmit side ahead of the DAC-rate filters.

---
 rtl/interpolate_4_if.sv | 22 ++
 rtl/interpolate_4.sv | 84 ++++++++
 tb/tb_interpolate_4.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interpolate_4_if.sv
// Sample-path bundle for the 1:4 interpolator: input handshake plus output
// sample stream and status.
interface interpolate_4_if #(
  parameter int W = 8
);
  logic signed [W-1:0] x;
  logic                x_valid;
  logic                x_ready;
  logic signed [W-1:0] y;
  logic                y_valid;
  logic                underrun;

  modport master (
    output x, x_valid,
    input  x_ready, y, y_valid, underrun
  );

  modport slave (
    input  x, x_valid,
    output x_ready, y, y_valid, underrun
  );
endinterface

// File: rtl/interpolate_4.sv
// Fixed 1:4 interpolator: takes one sample every fourth clock, emits one
// sample per clock by zero-stuffing, sample-hold or linear interpolation.
module interpolate_4 #(
  parameter int W    = 8,
  parameter int MODE = 2
) (
  input logic          clk,
  input logic          reset,
  interpolate_4_if.slave bus
);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  phase_t              p;
  phase_t              p_next;
  logic signed [W-1:0] prev;
  logic signed [W-1:0] cur;
  logic                primed;
  logic                underrun_q;
  logic signed [W-1:0] y_q;
  logic                y_valid_q;

  logic signed [W:0]   d;
  logic signed [W+2:0] prod;
  logic signed [W+2:0] step;
  logic signed [W-1:0] f;

  assign bus.x_ready  = (p == PH3) && !reset;
  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.underrun = underrun_q;

  always_comb begin
    p_next = PH0;
    case (p)
      PH0:     p_next = PH1;
      PH1:     p_next = PH2;
      PH2:     p_next = PH3;
      default: p_next = PH0;
    endcase
  end

  // d needs W+1 bits and p*d needs W+3; the floor shift keeps the result
  // between prev and cur, so the final W-bit truncation never loses data.
  always_comb begin
    d    = {cur[W-1], cur} - {prev[W-1], prev};
    prod = $signed({{2{d[W]}}, d}) * $signed({{(W+1){1'b0}}, p});
    step = prod >>> 2;
    f    = '0;
    if (MODE == 0) begin
      f = (p == PH0) ? cur : '0;
    end else if (MODE == 1) begin
      f = cur;
    end else begin
      f = W'({{3{prev[W-1]}}, prev} + step);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p          <= PH0;
      prev       <= '0;
      cur        <= '0;
      primed     <= 1'b0;
      underrun_q <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
    end else begin
      p         <= p_next;
      y_q       <= f;
      y_valid_q <= primed;
      if (p == PH3) begin
        prev <= cur;
        if (bus.x_valid) begin
          cur    <= bus.x;
          primed <= 1'b1;
        end else if (primed) begin
          underrun_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_interpolate_4.sv
// Scoreboard bench for interpolate_4: three instances (MODE 0/1/2) share one
// stimulus stream; expected frames are queued at each slot edge.
module tb_interpolate_4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [W-1:0] x = '0;
  logic x_valid = 1'b0;

  always #5 clk = ~clk;

  interpolate_4_if #(.W(W)) b0 ();
  interpolate_4_if #(.W(W)) b1 ();
  interpolate_4_if #(.W(W)) b2 ();

  assign b0.x = x;  assign b0.x_valid = x_valid;
  assign b1.x = x;  assign b1.x_valid = x_valid;
  assign b2.x = x;  assign b2.x_valid = x_valid;

  interpolate_4 #(.W(W), .MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  interpolate_4 #(.W(W), .MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  interpolate_4 #(.W(W), .MODE(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  typedef struct {
    logic signed [W-1:0] y0;
    logic signed [W-1:0] y1;
    logic signed [W-1:0] y2;
    logic                yv;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int mp = 0;
  logic signed [W-1:0] mprev = '0;
  logic signed [W-1:0] mcur = '0;
  logic mprimed = 1'b0;
  logic munder = 1'b0;

  function automatic logic signed [W-1:0] lin(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b,
                                              input int k);
    int dd;
    int t;
    dd = int'(b) - int'(a);
    t  = k * dd;
    return W'(int'(a) + (t >>> 2));
  endfunction

  task automatic push_frame(input logic yv);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.y0 = (k == 0) ? mcur : '0;
      e.y1 = mcur;
      e.y2 = lin(mprev, mcur, k);
      e.yv = yv;
      q.push_back(e);
    end
  endtask

  task automatic cycle(input logic rst, input logic v, input logic signed [W-1:0] s,
                       output logic signed [W-1:0] g0, output logic signed [W-1:0] g1,
                       output logic signed [W-1:0] g2);
    logic rdy;
    exp_t e;
    reset = rst; x_valid = v; x = s;
    #1;
    rdy = (mp == 3) && !rst;
    checks++;
    if (b2.x_ready !== rdy || b0.x_ready !== rdy) begin
      failures++;
      $display("FAIL x_ready: got %b/%b expected %b (phase %0d)", b0.x_ready, b2.x_ready, rdy, mp);
    end
    @(posedge clk); #1;
    e.y0 = '0; e.y1 = '0; e.y2 = '0; e.yv = 1'b0;
    if (rst) begin
      mp = 0; mprev = '0; mcur = '0; mprimed = 1'b0; munder = 1'b0;
      q.delete();
      push_frame(1'b0);
    end else begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL queue_empty: got 0 entries expected at least 1");
      end else begin
        e = q.pop_front();
      end
      if (rdy) begin
        mprev = mcur;
        if (v) begin
          mcur = s;
          mprimed = 1'b1;
        end else if (mprimed) begin
          munder = 1'b1;
        end
        push_frame(mprimed);
      end
      mp = (mp + 1) % 4;
    end
    checks++;
    if (b0.y !== e.y0) begin failures++; $display("FAIL y_mode0: got %0d expected %0d", b0.y, e.y0); end
    checks++;
    if (b1.y !== e.y1) begin failures++; $display("FAIL y_mode1: got %0d expected %0d", b1.y, e.y1); end
    checks++;
    if (b2.y !== e.y2) begin failures++; $display("FAIL y_mode2: got %0d expected %0d", b2.y, e.y2); end
    checks++;
    if (b2.y_valid !== e.yv || b0.y_valid !== e.yv) begin
      failures++;
      $display("FAIL y_valid: got %b/%b expected %b", b0.y_valid, b2.y_valid, e.yv);
    end
    checks++;
    if (b2.underrun !== munder || b0.underrun !== munder) begin
      failures++;
      $display("FAIL underrun: got %b/%b expected %b", b0.underrun, b2.underrun, munder);
    end
    g0 = b0.y; g1 = b1.y; g2 = b2.y;
  endtask

  task automatic run_frame(input logic [3:0] vm, input logic signed [W-1:0] s,
                           output logic [3:0][W-1:0] f0, output logic [3:0][W-1:0] f1,
                           output logic [3:0][W-1:0] f2);
    logic signed [W-1:0] a, b, c;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, vm[k], s, a, b, c);
      f0[k] = a; f1[k] = b; f2[k] = c;
    end
  endtask

  task automatic do_reset();
    logic signed [W-1:0] a, b, c;
    cycle(1'b1, 1'b0, '0, a, b, c);
  endtask

  task automatic test_reset();
    logic signed [W-1:0] a, b, c;
    int n;
    do_reset();
    do_reset();
    checks++;
    if (b2.y !== '0 || b2.y_valid !== 1'b0 || b2.underrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got y=%0d v=%b u=%b expected 0 0 0", b2.y, b2.y_valid, b2.underrun);
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (b2.x_ready === 1'b1) break;
      cycle(1'b0, 1'b0, '0, a, b, c);
      n++;
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL first_slot: got %0d cycles expected 3", n); end
  endtask

  task automatic test_linear_ramp();
    logic [3:0][W-1:0] f0, f1, f2;
    int ex[4];
    do_reset();
    run_frame(4'b1111, 8'sd0, f0, f1, f2);
    run_frame(4'b1111, 8'sd40, f0, f1, f2);
    ex = '{0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f2[k]) !== ex[k]) begin failures++; $display("FAIL ramp_f0[%0d]: got %0d expected %0d", k, $signed(f2[k]), ex[k]); end
    end
    checks++;
    if (b2.y_valid !== 1'b1) begin failures++; $display("FAIL ramp_valid: got %b expected 1", b2.y_valid); end
    run_frame(4'b1111, 8'sd40, f0, f1, f2);
    ex = '{0, 10, 20, 30};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f2[k]) !== ex[k]) begin failures++; $display("FAIL ramp_f1[%0d]: got %0d expected %0d", k, $signed(f2[k]), ex[k]); end
    end
    run_frame(4'b1111, 8'sd0, f0, f1, f2);
    ex = '{40, 40, 40, 40};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f2[k]) !== ex[k]) begin failures++; $display("FAIL ramp_f2[%0d]: got %0d expected %0d", k, $signed(f2[k]), ex[k]); end
    end
  endtask

  task automatic test_negative_floor();
    logic [3:0][W-1:0] f0, f1, f2;
    int ex[4];
    do_reset();
    run_frame(4'b1111, 8'sd0, f0, f1, f2);
    run_frame(4'b1111, -8'sd5, f0, f1, f2);
    run_frame(4'b1111, -8'sd5, f0, f1, f2);
    ex = '{0, -2, -3, -4};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f2[k]) !== ex[k]) begin failures++; $display("FAIL neg_floor[%0d]: got %0d expected %0d", k, $signed(f2[k]), ex[k]); end
    end
  endtask

  task automatic test_extremes();
    logic [3:0][W-1:0] f0, f1, f2;
    int ex[4];
    do_reset();
    run_frame(4'b1111, -8'sd128, f0, f1, f2);
    run_frame(4'b1111, 8'sd127, f0, f1, f2);
    run_frame(4'b1111, 8'sd127, f0, f1, f2);
    // -128 + floor(k*255/4)
    ex = '{-128, -65, -1, 63};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f2[k]) !== ex[k]) begin failures++; $display("FAIL extremes[%0d]: got %0d expected %0d", k, $signed(f2[k]), ex[k]); end
    end
  endtask

  task automatic test_zero_hold();
    logic [3:0][W-1:0] f0, f1, f2;
    int ez[4];
    int eh[4];
    do_reset();
    run_frame(4'b1111, 8'sd7, f0, f1, f2);
    run_frame(4'b1111, -8'sd3, f0, f1, f2);
    ez = '{7, 0, 0, 0}; eh = '{7, 7, 7, 7};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f0[k]) !== ez[k] || $signed(f1[k]) !== eh[k]) begin
        failures++;
        $display("FAIL zh_f0[%0d]: got %0d/%0d expected %0d/%0d", k, $signed(f0[k]), $signed(f1[k]), ez[k], eh[k]);
      end
    end
    run_frame(4'b1111, 8'sd0, f0, f1, f2);
    ez = '{-3, 0, 0, 0}; eh = '{-3, -3, -3, -3};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f0[k]) !== ez[k] || $signed(f1[k]) !== eh[k]) begin
        failures++;
        $display("FAIL zh_f1[%0d]: got %0d/%0d expected %0d/%0d", k, $signed(f0[k]), $signed(f1[k]), ez[k], eh[k]);
      end
    end
  endtask

  task automatic test_underrun();
    logic [3:0][W-1:0] f0, f1, f2;
    int ex[4];
    do_reset();
    run_frame(4'b0000, 8'sd9, f0, f1, f2);
    checks++;
    if (b2.underrun !== 1'b0) begin failures++; $display("FAIL pre_prime_underrun: got %b expected 0", b2.underrun); end
    run_frame(4'b1111, 8'sd20, f0, f1, f2);
    run_frame(4'b1111, 8'sd60, f0, f1, f2);
    run_frame(4'b0111, 8'sd99, f0, f1, f2);
    ex = '{20, 30, 40, 50};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f2[k]) !== ex[k]) begin failures++; $display("FAIL ur_ramp[%0d]: got %0d expected %0d", k, $signed(f2[k]), ex[k]); end
    end
    run_frame(4'b0111, 8'sd99, f0, f1, f2);
    ex = '{60, 60, 60, 60};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ($signed(f2[k]) !== ex[k]) begin failures++; $display("FAIL ur_flat[%0d]: got %0d expected %0d", k, $signed(f2[k]), ex[k]); end
    end
    checks++;
    if (b2.underrun !== 1'b1 || b2.y_valid !== 1'b1) begin
      failures++;
      $display("FAIL ur_sticky: got u=%b v=%b expected 1 1", b2.underrun, b2.y_valid);
    end
    run_frame(4'b1111, 8'sd1, f0, f1, f2);
    checks++;
    if (b2.underrun !== 1'b1) begin failures++; $display("FAIL ur_hold: got %b expected 1", b2.underrun); end
  endtask

  task automatic test_mid_reset();
    logic [3:0][W-1:0] f0, f1, f2;
    logic signed [W-1:0] a, b, c;
    int n;
    do_reset();
    run_frame(4'b1111, 8'sd50, f0, f1, f2);
    run_frame(4'b0000, 8'sd0, f0, f1, f2);
    cycle(1'b0, 1'b1, 8'sd10, a, b, c);
    cycle(1'b0, 1'b1, 8'sd10, a, b, c);
    do_reset();
    checks++;
    if (b2.y !== '0 || b2.y_valid !== 1'b0 || b2.underrun !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got y=%0d v=%b u=%b expected 0 0 0", b2.y, b2.y_valid, b2.underrun);
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (b2.x_ready === 1'b1) break;
      cycle(1'b0, 1'b0, '0, a, b, c);
      n++;
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL mid_reset_slot: got %0d cycles expected 3", n); end
  endtask

  task automatic test_back_to_back();
    logic [3:0][W-1:0] f0, f1, f2;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_frame(4'b1111, W'($urandom_range(0, 255)), f0, f1, f2);
    end
    run_frame(4'b1111, 8'sd0, f0, f1, f2);
  endtask

  initial begin
    test_reset();
    test_linear_ramp();
    test_negative_floor();
    test_extremes();
    test_zero_hold();
    test_underrun();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
